// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arb2.sv
// Two-way request arbiter for the data-memory controller.
// Build option DMEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed port-0 priority.
module dmem_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt
);
  import dmem_ctrl_pkg::*;

  assign gnt_valid = req0 | req1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last;

  // Pointer starts at the debug port so the first contended grant goes to the CPU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= P_DBG;
    end else if (accept) begin
      last <= gnt;
    end
  end

  always_comb begin
    gnt = P_CPU;
    if (req0 && req1) begin
      gnt = ~last;
    end else if (req1) begin
      gnt = P_DBG;
    end
  end
`else
  logic unused_arb;

  assign gnt         = req0 ? P_CPU : (req1 ? P_DBG : P_CPU);
  assign unused_arb  = ^{clk, rst_n, accept};
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// Serialising two-port front end for the word-access data memory; one access in flight at a time.
// Build option DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in dmem_arb2.
module dmem_access_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024,
  parameter int READ_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_ctrl_pkg::*;

  // Compared in full ADDR_W width so addresses near the top of the space cannot wrap into range.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

  state_e            state;
  logic              owner;
  logic [3:0]        wait_cnt;
  logic              gnt;
  logic              gnt_valid;
  logic              accept;
  logic              sel_we;
  logic              sel_bad;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign accept = (state == IDLE) && gnt_valid;

  always_comb begin
    sel_we    = (gnt == P_DBG) ? we1    : we0;
    sel_addr  = (gnt == P_DBG) ? addr1  : addr0;
    sel_wdata = (gnt == P_DBG) ? wdata1 : wdata0;
    sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
  end

  // Gated by rst_n so the stall also drops the moment reset is applied.
  assign cpu_stall = rst_n & req0 & ~ack0;

  // The wait counter runs READ_WAIT..0: the memory's output delay plus the capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= P_CPU;
      wait_cnt  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt;
            if (sel_bad) begin
              state <= DONE;
              if (gnt == P_DBG) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
              end
            end else if (sel_we) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
            end else begin
              state    <= READ;
              mem_re   <= 1'b1;
              mem_addr <= sel_addr;
              wait_cnt <= 4'(READ_WAIT);
            end
          end
        end
        WRITE: begin
          state     <= DONE;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (owner == P_DBG) begin
            ack1 <= 1'b1;
          end else begin
            ack0 <= 1'b1;
          end
        end
        READ: begin
          if (wait_cnt == 4'd0) begin
            state    <= DONE;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            if (owner == P_DBG) begin
              rdata1 <= mem_rdata;
              ack1   <= 1'b1;
            end else begin
              rdata0 <= mem_rdata;
              ack0   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
